// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, geometry and
// small helpers for classifying a row sample.
package keypad_scanner_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // True when exactly one row line is pulled low.
  function automatic logic row_is_single(input logic [ROWS-1:0] rows);
    logic [2:0] zeros;
    zeros = 3'd0;
    for (int i = 0; i < ROWS; i++) begin
      zeros = zeros + {2'b00, ~rows[i]};
    end
    return (zeros == 3'd1);
  endfunction

  function automatic logic [1:0] row_low_idx(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad row lines into clk;
// resets to the idle (all rows high) pattern.
module keypad_row_sync
  import keypad_scanner_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [ROWS-1:0] row_s
);

  logic [ROWS-1:0] meta_r;
  logic [ROWS-1:0] sync_r;

  // Metastability filter: capture stage followed by a settling stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= ROW_IDLE;
      sync_r <= ROW_IDLE;
    end else begin
      meta_r <= row_in;
      sync_r <= meta_r;
    end
  end

  assign row_s = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotating column strobe, debounced
// press/release detection, one key_valid pulse per physical press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE_N + 1);
  localparam int CW = $clog2(COLS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_N - 1);

  logic [ROWS-1:0]   row_s;
  logic [TW-1:0]     tick_cnt_r;
  logic              tick_s;

  state_e            state_r,   state_nx;
  logic [CW-1:0]     col_idx_r, col_idx_nx;
  logic [COLS-1:0]   col_out_r, col_out_nx;
  logic [ROWS-1:0]   pat_r,     pat_nx;
  logic [MW-1:0]     match_r,   match_nx;
  logic [CODE_W-1:0] code_r,    code_nx;
  logic              valid_r,   valid_nx;
  logic              held_r,    held_nx;

  keypad_row_sync u_row_sync (
    .clk    (clk),
    .rst    (rst),
    .row_in (row_in),
    .row_s  (row_s)
  );

  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Column slot timer; the tick marks the last cycle of each slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1'b1);
    end
  end

  // Next-state and datapath decisions, evaluated only on tick cycles
  always_comb begin
    state_nx   = state_r;
    col_idx_nx = col_idx_r;
    pat_nx     = pat_r;
    match_nx   = match_r;
    code_nx    = code_r;
    valid_nx   = 1'b0;
    held_nx    = held_r;
    if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (row_is_single(row_s)) begin
            pat_nx   = row_s;
            match_nx = {MW{1'b0}};
            state_nx = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx_r + CW'(1'b1);
          end
        end
        DEBOUNCE: begin
          if (row_s == pat_r) begin
            if (match_r == MATCH_LAST) begin
              code_nx  = {row_low_idx(pat_r), col_idx_r};
              valid_nx = 1'b1;
              held_nx  = 1'b1;
              match_nx = {MW{1'b0}};
              state_nx = HELD;
            end else begin
              match_nx = match_r + MW'(1'b1);
            end
          end else begin
            // Bounce or multi-key sample: give up and move on to the next column
            state_nx   = SCAN;
            col_idx_nx = col_idx_r + CW'(1'b1);
          end
        end
        HELD: begin
          if (row_s == ROW_IDLE) begin
            match_nx = {MW{1'b0}};
            state_nx = RELEASE;
          end else begin
            state_nx = HELD;
          end
        end
        RELEASE: begin
          if (row_s == ROW_IDLE) begin
            if (match_r == MATCH_LAST) begin
              held_nx    = 1'b0;
              match_nx   = {MW{1'b0}};
              state_nx   = SCAN;
              col_idx_nx = col_idx_r + CW'(1'b1);
            end else begin
              match_nx = match_r + MW'(1'b1);
            end
          end else begin
            state_nx = HELD;
          end
        end
        default: begin
          state_nx = SCAN;
        end
      endcase
    end else begin
      state_nx = state_r;
    end
    col_out_nx = ~({{(COLS-1){1'b0}}, 1'b1} << col_idx_nx);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= SCAN;
      col_idx_r <= {CW{1'b0}};
      col_out_r <= 4'b1110;
      pat_r     <= ROW_IDLE;
      match_r   <= {MW{1'b0}};
      code_r    <= {CODE_W{1'b0}};
      valid_r   <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      col_idx_r <= col_idx_nx;
      col_out_r <= col_out_nx;
      pat_r     <= pat_nx;
      match_r   <= match_nx;
      code_r    <= code_nx;
      valid_r   <= valid_nx;
      held_r    <= held_nx;
    end
  end

  assign col_out   = col_out_r;
  assign key_code  = code_r;
  assign key_valid = valid_r;
  assign key_held  = held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a tick-level behavioural model checked
// every cycle, plus hand-computed literal expectations.
module tb_keypad_scanner;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic cmp_en = 1'b0;

  // Model of the observable behaviour, advanced once per clock edge
  int         m_edges  = 0;
  int         m_col    = 0;
  int         m_streak = 0;
  int         m_mode   = 0;   // 0 scanning, 1 confirming press, 2 key down, 3 confirming release
  logic [3:0] m_pat    = 4'hF;
  logic [3:0] m_hist1  = 4'hF;
  logic [3:0] m_hist2  = 4'hF;
  logic [3:0] m_code   = 4'h0;
  logic       m_valid  = 1'b0;
  logic       m_held   = 1'b0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_N(DEBOUNCE_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_col(input logic [3:0] pat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (col_out !== pat && n < 40);
    check4("wait_col", col_out, pat);
  endtask

  initial begin : model
    logic [3:0] rs;
    int idx;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_edges = 0; m_col = 0; m_streak = 0; m_mode = 0;
        m_pat = 4'hF; m_hist1 = 4'hF; m_hist2 = 4'hF;
        m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
      end else begin
        rs = m_hist2;          // rows as seen two edges after they were driven
        m_hist2 = m_hist1;
        m_hist1 = row_in;
        m_edges++;
        m_valid = 1'b0;
        if (m_edges % SCAN_DIV == 0) begin
          case (m_mode)
            0: if ($countones(~rs) == 1) begin
                 m_pat = rs; m_streak = 0; m_mode = 1;
               end else m_col = (m_col + 1) % 4;
            1: if (rs == m_pat) begin
                 m_streak++;
                 if (m_streak == DEBOUNCE_N) begin
                   idx = 0;
                   for (int i = 0; i < 4; i++) if (!rs[i]) idx = i;
                   m_code = 4'(idx * 4 + m_col);
                   m_valid = 1'b1; m_held = 1'b1; m_mode = 2;
                 end
               end else begin
                 m_mode = 0; m_col = (m_col + 1) % 4;
               end
            2: if (rs == 4'hF) begin m_streak = 0; m_mode = 3; end
            default: if (rs == 4'hF) begin
                 m_streak++;
                 if (m_streak == DEBOUNCE_N) begin
                   m_held = 1'b0; m_mode = 0; m_col = (m_col + 1) % 4;
                 end
               end else m_mode = 2;
          endcase
        end
      end
    end
  end

  initial begin : compare
    logic [3:0] ec;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      if (cmp_en) begin
        ec = ~(4'b0001 << m_col);
        check4("model_col", col_out, ec);
        check4("model_code", key_code, m_code);
        check4("model_valid", {3'b000, key_valid}, {3'b000, m_valid});
        check4("model_held", {3'b000, key_held}, {3'b000, m_held});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    int p0;
    logic [3:0] exp_col;
    rst = 1'b0;
    row_in = 4'hF;
    repeat (3) @(negedge clk);
    check4("reset_col", col_out, 4'b1110);
    check4("reset_code", key_code, 4'h0);
    check4("reset_valid", {3'b000, key_valid}, 4'h0);
    check4("reset_held", {3'b000, key_held}, 4'h0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Idle rotation: column index advances every SCAN_DIV edges
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check4("idle_col", col_out, exp_col);
    end
    check_int("idle_pulses", pulses, 0);

    // Row 2 pressed at column 1 -> code 9 after (1+3) ticks = 16 cycles
    wait_col(4'b1101);
    row_in = 4'b1011;
    p0 = pulses;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 8) check4("freeze_col", col_out, 4'b1101);
    end while (key_valid !== 1'b1 && lat < 40);
    check_int("press_latency", lat, 16);
    check4("press_code", key_code, 4'd9);
    check4("press_held", {3'b000, key_held}, 4'h1);

    // Release with a one-tick glitch in the middle
    row_in = 4'hF;
    repeat (8) @(negedge clk);
    row_in = 4'b1011;
    repeat (4) @(negedge clk);
    check4("glitch_held", {3'b000, key_held}, 4'h1);
    row_in = 4'hF;
    repeat (17) @(negedge clk);
    check4("release_held", {3'b000, key_held}, 4'h0);
    check4("release_col", col_out, 4'b1011);
    check_int("press_pulses", pulses - p0, 1);

    // Bounce: row 0 at column 3 for two ticks, then released
    wait_col(4'b0111);
    p0 = pulses;
    row_in = 4'b1110;
    repeat (8) @(negedge clk);
    row_in = 4'hF;
    repeat (4) @(negedge clk);
    check4("bounce_col", col_out, 4'b1110);
    check4("bounce_code", key_code, 4'd9);
    check_int("bounce_pulses", pulses - p0, 0);

    // Two rows low in column 0: ignored, scanning continues
    row_in = 4'b1010;
    repeat (5) @(negedge clk);
    check4("dual_col", col_out, 4'b1101);
    repeat (16) @(negedge clk);
    check_int("dual_pulses", pulses - p0, 0);
    check4("dual_held", {3'b000, key_held}, 4'h0);
    row_in = 4'hF;
    repeat (4) @(negedge clk);

    // Reset asserted between edges while debouncing row 1 at column 2
    wait_col(4'b1011);
    row_in = 4'b1101;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check4("rst_col", col_out, 4'b1110);
    check4("rst_code", key_code, 4'h0);
    check4("rst_valid", {3'b000, key_valid}, 4'h0);
    check4("rst_held", {3'b000, key_held}, 4'h0);
    row_in = 4'hF;
    @(negedge clk);
    p0 = pulses;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check4("restart_col0", col_out, 4'b1110);
    repeat (2) @(negedge clk);
    check4("restart_col1", col_out, 4'b1101);
    repeat (30) @(negedge clk);
    check_int("restart_pulses", pulses - p0, 0);
    check4("restart_code", key_code, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
